instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Requester-side fetch unit that reads 128-bit lines from the instruction memory and returns 32-bit instructions to the core.
//  The memory gives no valid strobe; it returns X until its fixed access latency has elapsed after an address change.
//  This block therefore holds the line address stable, counts the latency itself and captures the line.
//  Captured lines go into a small direct-mapped line buffer; hits return in 1 cycle.
// PARAMETERS
//  MEM_LATENCY  7  edges memAddress must be held stable before memData is valid (>=1)
//  LINES        4  line-buffer entries, power of 2 (>=1); INDEX_W = log2(LINES), 0 when LINES=1
// PORTS
//  clock        in   1    single clock, all state updates on posedge
//  resetN       in   1    synchronous, active-low reset
//  fetchReq     in   1    core requests the instruction at fetchAddr
//  fetchAddr    in   32   byte address; bits [1:0] ignored
//  fetchReady   out  1    = (state==IDLE) && flush==0 (combinational); request accepted when fetchReq && fetchReady
//  instrValid   out  1    registered 1-cycle pulse: instruction is valid
//  instruction  out  32   returned word; holds its value until the next instrValid
//  flush        in   1    invalidate every buffer line; abort any miss in progress
//  memAddress   out  32   line address to instruction memory, {tag,index,4'b0000}
//  memData      in   128  line from instruction memory; byte at offset 0 in bits [127:120]
// BEHAVIOUR
//  Reset (resetN==0 at an edge): state=IDLE, instrValid=0, instruction=0, memAddress=0, waitCount=0, all line valid bits=0.
//  Address split: offset=fetchAddr[3:2]; index=fetchAddr[4 +: INDEX_W]; tag=fetchAddr[31:4+INDEX_W].
//  Word select: word k = line[127-32k -: 32], k = offset.
//  FSM states: IDLE, FETCH.
//  IDLE, request accepted, hit (valid[index] && tag match):
//   - instruction <= word from the buffer, instrValid <= 1 at the same edge; remain IDLE.
//  IDLE, request accepted, miss:
//   - latch offset/index/tag; memAddress <= {fetchAddr[31:4],4'b0}; waitCount <= MEM_LATENCY; go to FETCH.
//  FETCH, waitCount != 0: decrement waitCount; memAddress held unchanged.
//  FETCH, waitCount == 0:
//   - write memData to the line (data, tag, valid=1); instruction <= selected word from memData; instrValid <= 1; go to IDLE.
//  Latency: hit response is visible 1 cycle after the accept edge; miss response is visible MEM_LATENCY+1 edges after the accept edge.
//  In IDLE and while no request is accepted, memAddress keeps its last value, so the memory does not re-enter its invalid window.
//  Re-fetching the same line after a flush still waits the full MEM_LATENCY.
//  instrValid is 0 on every edge that does not produce a response.
//  flush (any state): all valid bits cleared at that edge; FETCH aborts to IDLE with no response and no line write; flush overrides a same-cycle fetchReq.
//  Reset mid-miss: behaves as a plain reset; no response is produced.
//  A miss to an index evicts the resident line unconditionally (no write-back; the buffer is read-only).
//  memData is sampled only on the capture edge; X at any other time is legal.
// STRUCTURE
//  Package ifetch_pkg:
//   - constants LINE_W=128, WORD_W=32, LINE_BYTES=16, OFFSET_W=4
//   - state enum {IDLE, FETCH}
//   - function word_select(line, offset)
//  Sub-module ifetch_line_store: per-entry valid/tag/data arrays; flush-clear and single write port; combinational read by index.
//  Top level: FSM, waitCount, memAddress register, output registers.
// TESTING
//  1 Reset, then fetchReq with fetchAddr=0x0000_0004:
//    - miss; memAddress=0x0000_0000 for 8 edges, fetchReady=0 during FETCH
//    - instrValid pulses once with memData[95:64]
//  2 After test 1, fetchReq at 0x0000_000C -> instrValid the next cycle with memData[31:0]; memAddress unchanged.
//  3 Conflict: with LINES=4, fetch 0x0000_0000 then 0x0000_0040 (same index) -> both miss; a re-fetch of 0x0000_0000 misses again.
//  4 Flush asserted on the 3rd edge of a miss:
//    - no instrValid; IDLE next cycle; the line remains invalid
//    - fetchReq held high alongside flush is not accepted.
//  5 resetN=0 mid-FETCH:
//    - all outputs return to reset values and no instrValid is produced
//    - a subsequent hit-candidate address misses.
//  6 Memory model drives X except in its valid window:
//    - assert instruction never carries X when instrValid=1
//    - assert memAddress is stable throughout FETCH.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared constants, FSM state encoding and line word-select helper for the fetch unit.
package ifetch_pkg;

    localparam int LINE_W     = 128;
    localparam int WORD_W     = 32;
    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // Byte 0 of the line sits in the top bits, so word 0 is the most significant word.
    function automatic logic [WORD_W-1:0] word_select(input logic [LINE_W-1:0] line,
                                                      input logic [1:0]        offset);
        logic [WORD_W-1:0] w;
        case (offset)
            2'd0:    w = line[127:96];
            2'd1:    w = line[95:64];
            2'd2:    w = line[63:32];
            default: w = line[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Core-side fetch handshake plus the instruction-memory address/data pair.
interface instruction_fetch_unit_if;

    logic         fetchReq;
    logic [31:0]  fetchAddr;
    logic         fetchReady;
    logic         instrValid;
    logic [31:0]  instruction;
    logic         flush;
    logic [31:0]  memAddress;
    logic [127:0] memData;

    modport master (
        output fetchReq, fetchAddr, flush, memData,
        input  fetchReady, instrValid, instruction, memAddress
    );

    modport slave (
        input  fetchReq, fetchAddr, flush, memData,
        output fetchReady, instrValid, instruction, memAddress
    );

endinterface

// File: rtl/ifetch_line_store.sv
// Direct-mapped line buffer: valid/tag/data per entry, flush clears all valid bits.
module ifetch_line_store
    import ifetch_pkg::*;
#(
    parameter int LINES = 4,
    parameter int IDX_W = 2,
    parameter int TAG_W = 26
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_index,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_index,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_data
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are never used while the valid bit is clear.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: serves hits from the line buffer, otherwise holds memAddress for
// MEM_LATENCY edges and captures the line on the following edge.
//   state | meaning
//   IDLE  | accepting requests; hits answered at the accept edge
//   FETCH | memAddress held, counting down the memory latency
module instruction_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int MEM_LATENCY = 7,
    parameter int LINES       = 4
) (
    input logic                     clock,
    input logic                     resetN,
    instruction_fetch_unit_if.slave bus
);

    localparam int INDEX_W = (LINES > 1) ? $clog2(LINES) : 0;
    localparam int IDX_W   = (INDEX_W > 0) ? INDEX_W : 1;
    localparam int TAG_W   = 32 - OFFSET_W - INDEX_W;
    localparam int CNT_W   = $clog2(MEM_LATENCY + 1);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_FETCH = FETCH;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_wait_count;
    logic [31:0]       r_mem_address;
    logic              r_instr_valid;
    logic [31:0]       r_instruction;
    logic [1:0]        r_offset;
    logic [IDX_W-1:0]  r_index;
    logic [TAG_W-1:0]  r_tag;

    logic              w_accept;
    logic              w_hit;
    logic              w_capture;
    logic [1:0]        w_offset;
    logic [IDX_W-1:0]  w_index;
    logic [TAG_W-1:0]  w_tag;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [LINE_W-1:0] w_rd_data;

    generate
        if (INDEX_W > 0) begin : g_index
            assign w_index = bus.fetchAddr[OFFSET_W +: INDEX_W];
        end else begin : g_no_index
            assign w_index = '0;
        end
    endgenerate

    assign w_offset       = bus.fetchAddr[3:2];
    assign w_tag          = bus.fetchAddr[31:OFFSET_W+INDEX_W];
    assign bus.fetchReady = (r_state == ST_IDLE) && !bus.flush;
    assign w_accept       = bus.fetchReq && bus.fetchReady;
    assign w_hit          = w_rd_valid && (w_rd_tag == w_tag);
    assign w_capture      = (r_state == ST_FETCH) && (r_wait_count == '0) && !bus.flush;

    ifetch_line_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_line_store (
        .i_clock    (clock),
        .i_reset_n  (resetN),
        .i_flush    (bus.flush),
        .i_wr_en    (w_capture),
        .i_wr_index (r_index),
        .i_wr_tag   (r_tag),
        .i_wr_data  (bus.memData),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state       <= ST_IDLE;
            r_wait_count  <= '0;
            r_mem_address <= '0;
            r_instr_valid <= 1'b0;
            r_instruction <= '0;
            r_offset      <= '0;
            r_index       <= '0;
            r_tag         <= '0;
        end else begin
            r_instr_valid <= 1'b0;
            if (bus.flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept && w_hit) begin
                            r_instruction <= word_select(w_rd_data, w_offset);
                            r_instr_valid <= 1'b1;
                        end else if (w_accept) begin
                            r_offset      <= w_offset;
                            r_index       <= w_index;
                            r_tag         <= w_tag;
                            r_mem_address <= {bus.fetchAddr[31:OFFSET_W], 4'b0000};
                            r_wait_count  <= CNT_W'(MEM_LATENCY);
                            r_state       <= ST_FETCH;
                        end
                    end
                    default: begin
                        if (r_wait_count != '0) begin
                            r_wait_count <= r_wait_count - 1'b1;
                        end else begin
                            r_instruction <= word_select(bus.memData, r_offset);
                            r_instr_valid <= 1'b1;
                            r_state       <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.instrValid  = r_instr_valid;
    assign bus.instruction = r_instruction;
    assign bus.memAddress  = r_mem_address;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with an X-outside-window memory model.
module tb_instruction_fetch_unit;

    localparam int LAT = 7;

    typedef struct {
        logic [31:0] instr;
        int          cyc;
    } exp_t;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.MEM_LATENCY(LAT), .LINES(4)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a ^ 32'h1111_1111, a ^ 32'h2222_2222, a ^ 32'h3333_3333, a ^ 32'h4444_4444};
    endfunction

    // Memory: data valid only once memAddress has been stable for LAT edges after a miss accept.
    initial begin
        int          cnt = LAT;
        logic [31:0] last = 32'h0;
        bus.memData = 'x;
        forever begin
            @(negedge clock);
            #2;
            if (bus.fetchReq && bus.fetchReady) cnt = -1;
            else if (bus.memAddress != last)    cnt = 0;
            else if (cnt < LAT)                 cnt++;
            last = bus.memAddress;
            bus.memData = (cnt >= LAT) ? line_of(last) : 'x;
        end
    end

    // Response monitor.
    always @(negedge clock) begin
        if (bus.instrValid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got instruction %h expected no response", bus.instruction);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("instr", bus.instruction, e.instr);
                check("latency", cyc, e.cyc);
                n_checks++;
                if ($isunknown(bus.instruction)) begin
                    n_errors++;
                    $display("FAIL instr_x: got %h expected known value", bus.instruction);
                end
            end
        end
    end

    // memAddress must not move while a miss is in progress.
    logic        prev_busy = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clock) begin
        if (resetN && !bus.fetchReady && !bus.flush && prev_busy)
            check("mem_addr_stable", bus.memAddress, prev_addr);
        prev_busy = resetN && !bus.fetchReady && !bus.flush;
        prev_addr = bus.memAddress;
    end

    // kind: 0 hit, 1 miss, 2 aborted (no response expected)
    task automatic issue(input logic [31:0] a, input logic [31:0] exp, input int kind);
        int t = 0;
        exp_t e;
        @(negedge clock);
        while (!bus.fetchReady && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got fetchReady=0 expected 1 within 100 cycles");
        end
        bus.fetchReq  = 1'b1;
        bus.fetchAddr = a;
        if (kind != 2) begin
            e.instr = exp;
            e.cyc   = cyc + ((kind == 0) ? 1 : LAT + 2);
            sb_q.push_back(e);
        end
        @(negedge clock);
        bus.fetchReq = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb_q.size() != 0 || !bus.fetchReady) && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int t;
        bus.fetchReq  = 1'b0;
        bus.fetchAddr = '0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(bus.instrValid), 32'd0);
        check("rst_instr", bus.instruction, 32'h0);
        check("rst_mem_addr", bus.memAddress, 32'h0);
        check("rst_ready", 32'(bus.fetchReady), 32'd1);
        resetN = 1'b1;

        // 1: cold miss
        issue(32'h0000_0004, 32'h2222_2222, 1);
        nb = 0;
        t  = 0;
        while (!bus.fetchReady && t < 50) begin
            if (bus.memAddress == 32'h0) nb++;
            @(negedge clock);
            t++;
        end
        check("fetch_busy_edges", 32'(nb), 32'd8);
        wait_idle();
        check("mem_addr_line0", bus.memAddress, 32'h0);

        // 2: hit on the same line
        issue(32'h0000_000C, 32'h4444_4444, 0);
        wait_idle();
        check("mem_addr_after_hit", bus.memAddress, 32'h0);
        repeat (3) @(negedge clock);
        check("instr_hold", bus.instruction, 32'h4444_4444);

        // 3: conflict misses on index 0
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        issue(32'h0000_0000, 32'h1111_1111, 1);
        issue(32'h0000_0040, 32'h1111_1151, 1);
        check("mem_addr_conflict", bus.memAddress, 32'h0000_0040);
        issue(32'h0000_0000, 32'h1111_1111, 1);
        issue(32'h0000_0008, 32'h3333_3333, 0);
        wait_idle();

        // 4: flush on the 3rd edge of a miss
        issue(32'h0000_0100, 32'h0, 2);
        @(negedge clock);
        @(negedge clock);
        bus.flush     = 1'b1;
        bus.fetchReq  = 1'b1;
        bus.fetchAddr = 32'h0000_0104;
        #1;
        check("ready_during_flush", 32'(bus.fetchReady), 32'd0);
        @(negedge clock);
        bus.flush    = 1'b0;
        bus.fetchReq = 1'b0;
        #1;
        check("idle_after_flush", 32'(bus.fetchReady), 32'd1);
        repeat (12) @(negedge clock);
        issue(32'h0000_0104, 32'h2222_2322, 1);
        issue(32'h0000_0008, 32'h3333_3333, 1);
        wait_idle();

        // 5: reset in the middle of a miss
        issue(32'h0000_0304, 32'h2222_2122, 1);
        issue(32'h0000_0308, 32'h3333_3033, 0);
        wait_idle();
        issue(32'h0000_0200, 32'h0, 2);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b0;
        @(negedge clock);
        check("midrst_valid", 32'(bus.instrValid), 32'd0);
        check("midrst_instr", bus.instruction, 32'h0);
        check("midrst_mem_addr", bus.memAddress, 32'h0);
        check("midrst_ready", 32'(bus.fetchReady), 32'd1);
        resetN = 1'b1;
        repeat (12) @(negedge clock);
        issue(32'h0000_0304, 32'h2222_2122, 1);
        wait_idle();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
